// File: rtl/booth_mul_p.sv
// Sequential radix-2 Booth multiplier, WIDTH-bit operands, per-op signed/unsigned, 2*WIDTH-bit product.
// Latency: WIDTH+1 cycles (signed) or WIDTH+2 cycles (unsigned) from the accepting edge to the done pulse.
// Backpressure: busy is high outside IDLE; start is ignored while busy and there is no request queue.
// Optional overflow flag is built only when BOOTH_MUL_P_OVF_EN is defined; otherwise ovf is tied low.
module booth_mul_p #(
  parameter int         WIDTH    = 16,
  parameter logic [3:0] DTYPE_ID = 4'h1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           dtype,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Q,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf
);

  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  state_t          state_nx;
  logic [WIDTH:0]  a_r;
  logic [WIDTH:0]  m_r;
  logic [WIDTH:0]  q_r;
  logic            qm1_r;
  logic            sgn_r;
  logic [CW-1:0]   cnt_r;
  logic            accept;
  logic            last;
  logic [WIDTH:0]  a_sum;
  logic [2*WIDTH-1:0] prod;

  assign accept = start && (dtype == DTYPE_ID);
  assign last   = (cnt_r == '0);
  assign busy   = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: accept only in IDLE, leave CALC once every step has been applied.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = CALC;
      CALC:    if (last)   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Booth step: inspect {q[0], q_-1}; subtract on 10, add on 01, hold otherwise.
  always_comb begin
    a_sum = a_r;
    case ({q_r[0], qm1_r})
      2'b10:   a_sum = a_r - m_r;
      2'b01:   a_sum = a_r + m_r;
      default: a_sum = a_r;
    endcase
  end

  // Product alignment: signed runs WIDTH steps, so the multiplier's extension bit
  // is still sitting in q[0]; unsigned runs WIDTH+1 steps and q is all product bits.
  always_comb begin
    prod = '0;
    if (sgn_r) prod = {a_r[WIDTH-1:0], q_r[WIDTH:1]};
    else       prod = {a_r[WIDTH-2:0], q_r};
  end

  // Datapath: operand capture on accept, one shift-add step per CALC cycle, result load on exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= '0;
      m_r    <= '0;
      q_r    <= '0;
      qm1_r  <= 1'b0;
      sgn_r  <= 1'b0;
      cnt_r  <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            m_r   <= sgn ? {M[WIDTH-1], M} : {1'b0, M};
            q_r   <= sgn ? {Q[WIDTH-1], Q} : {1'b0, Q};
            a_r   <= '0;
            qm1_r <= 1'b0;
            sgn_r <= sgn;
            cnt_r <= sgn ? CW'(WIDTH) : CW'(WIDTH + 1);
          end
        end
        CALC: begin
          if (!last) begin
            a_r   <= {a_sum[WIDTH], a_sum[WIDTH:1]};
            q_r   <= {a_sum[0], q_r[WIDTH:1]};
            qm1_r <= q_r[0];
            cnt_r <= cnt_r - 1'b1;
          end else begin
            result <= prod;
          end
        end
        default: ;
      endcase
    end
  end

  // Done pulse: registered on the same edge that loads result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done <= 1'b0;
    else     done <= (state == CALC) && last;
  end

`ifdef BOOTH_MUL_P_OVF_EN
  // Overflow: product does not fit back into WIDTH bits of the operand's own type.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if ((state == CALC) && last) begin
      if (sgn_r) ovf <= !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
      else       ovf <= |prod[2*WIDTH-1:WIDTH];
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
